// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: command opcodes, FSM states and word geometry.
package spi_pkg;

  localparam int WORD_W = 32;

  localparam logic [7:0] CMD_SRD = 8'h00;
  localparam logic [7:0] CMD_SWR = 8'h01;
  localparam logic [7:0] CMD_BRD = 8'h20;
  localparam logic [7:0] CMD_BWR = 8'h21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_DATA,
    ST_POST,
    ST_DONE
  } state_t;

  // Number of data words a request carries; zero marks a request to reject.
  function automatic logic [7:0] word_count(input logic [7:0] rw, input logic [7:0] brstlen);
    case (rw)
      CMD_SRD, CMD_SWR: return 8'd1;
      CMD_BRD, CMD_BWR: return brstlen;
      default:          return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/spim_clk_gate.sv
// SPI clock gate: sclk is the inverted free-running clock ANDed with a registered enable.
module spim_clk_gate (
  input  logic sclk_inv,
  input  logic en,
  output logic sclk
);

  // en only changes while ~sclk_inv is low, so the AND cannot glitch.
  assign sclk = ~sclk_inv & en;

endmodule

// File: rtl/spim_intf.sv
// CPOL=0/CPHA=0 SPI master: frames a 32-bit command word plus N data words, MSB first.
module spim_intf
  import spi_pkg::*;
#(
  parameter int SS_GAP = 4
) (
  input  logic              sclk_inv,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        cmd_rw,
  input  logic [7:0]        cmd_brstlen,
  input  logic [15:0]       cmd_addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [WORD_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
  output logic              sclk,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CW = 5;
  localparam logic [CW-1:0] GAP_LAST = CW'(SS_GAP - 1);
  localparam logic [CW-1:0] BIT_LAST = '1;

  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [7:0]        word_cnt;
  logic [WORD_W-1:0] cmd_word;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-1:0] rx_shift;
  logic              sclk_en;
  logic [7:0]        req_words;
  logic              is_write;

  assign req_words = word_count(cmd_rw, cmd_brstlen);
  assign is_write  = cmd_word[24];

  spim_clk_gate u_clk_gate (
    .sclk_inv (sclk_inv),
    .en       (sclk_en),
    .sclk     (sclk)
  );

  // miso is sampled on sclk rising, half a cycle after the slave drove it.
  always_ff @(negedge sclk_inv or negedge rst_n) begin
    if (!rst_n) rx_shift <= '0;
    else        rx_shift <= {rx_shift[WORD_W-2:0], miso};
  end

  always_ff @(posedge sclk_inv or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      cmd_word    <= '0;
      tx_shift    <= '0;
      sclk_en     <= 1'b0;
      ss_n        <= 1'b1;
      mosi        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wdata_ack   <= 1'b0;
    end else begin
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      wdata_ack   <= 1'b0;
      rdata_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (req_words != 8'd0) begin
              cmd_word <= {cmd_rw, cmd_brstlen, cmd_addr};
              word_cnt <= req_words;
              busy     <= 1'b1;
              sclk_en  <= 1'b1;
              bit_cnt  <= '0;
              state    <= ST_PRE;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end

        ST_PRE: begin
          if (bit_cnt == GAP_LAST) begin
            ss_n     <= 1'b0;
            tx_shift <= cmd_word;
            mosi     <= cmd_word[WORD_W-1];
            bit_cnt  <= '0;
            state    <= ST_CMD;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_CMD: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            if (is_write) begin
              tx_shift  <= wdata;
              mosi      <= wdata[WORD_W-1];
              wdata_ack <= 1'b1;
            end else begin
              tx_shift <= '0;
              mosi     <= 1'b0;
            end
            state <= ST_DATA;
          end else begin
            tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
            mosi     <= tx_shift[WORD_W-2];
          end
        end

        ST_DATA: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            if (!is_write) begin
              rdata       <= rx_shift;
              rdata_valid <= 1'b1;
            end
            word_cnt <= word_cnt - 8'd1;
            if (word_cnt == 8'd1) begin
              ss_n    <= 1'b1;
              mosi    <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_POST;
            end else if (is_write) begin
              tx_shift  <= wdata;
              mosi      <= wdata[WORD_W-1];
              wdata_ack <= 1'b1;
            end else begin
              tx_shift <= '0;
              mosi     <= 1'b0;
            end
          end else begin
            tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
            mosi     <= tx_shift[WORD_W-2];
          end
        end

        // Trailing gap keeps sclk running with ss_n high so the slave sees the rising edge.
        ST_POST: begin
          if (bit_cnt == GAP_LAST) begin
            sclk_en <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spim_intf.sv
// Directed testbench for spim_intf: a pin monitor reassembles mosi frames and a
// small slave model returns a fixed miso word in every data slot.
module tb_spim_intf;

  localparam int SS_GAP = 4;

  logic        sclk_inv = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  cmd_rw = 8'h00;
  logic [7:0]  cmd_brstlen = 8'h00;
  logic [15:0] cmd_addr = 16'h0000;
  logic [31:0] wdata = 32'h0;
  logic        wdata_ack;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        done;
  logic        cmd_err;
  logic        sclk;
  logic        ss_n;
  logic        mosi;
  logic        miso;

  int compared = 0;
  int mismatched = 0;

  int          cyc = 0;
  int          busy_total = 0;
  int          ack_total = 0;
  int          rv_total = 0;
  int          done_total = 0;
  int          err_total = 0;
  int          ack_cyc[$];
  logic [31:0] mosi_words[$];
  int          k = 0;
  int          gap_cnt = 0;
  int          frame_len = 0;
  int          last_gap = 0;
  int          last_post = 0;
  logic [31:0] mosi_sr = 32'h0;
  logic [31:0] miso_reply = 32'h0;

  spim_intf #(.SS_GAP(SS_GAP)) dut (
    .sclk_inv    (sclk_inv),
    .rst_n       (rst_n),
    .start       (start),
    .cmd_rw      (cmd_rw),
    .cmd_brstlen (cmd_brstlen),
    .cmd_addr    (cmd_addr),
    .wdata       (wdata),
    .wdata_ack   (wdata_ack),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .done        (done),
    .cmd_err     (cmd_err),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .miso        (miso)
  );

  always #5 sclk_inv = ~sclk_inv;

  assign miso = (!ss_n && k >= 32) ? miso_reply[31 - (k % 32)] : 1'b0;

  // Slave-side view: count sclk edges inside and outside the frame and rebuild mosi words.
  always @(posedge sclk) begin
    if (ss_n) begin
      gap_cnt <= gap_cnt + 1;
      if (k != 0) begin
        frame_len <= k;
        k <= 0;
      end
    end else begin
      if (k == 0) last_gap <= gap_cnt;
      gap_cnt <= 0;
      k <= k + 1;
      mosi_sr <= {mosi_sr[30:0], mosi};
      if (k % 32 == 31) mosi_words.push_back({mosi_sr[30:0], mosi});
    end
  end

  always @(negedge sclk_inv) begin
    cyc <= cyc + 1;
    if (busy) busy_total <= busy_total + 1;
    if (wdata_ack) begin
      ack_total <= ack_total + 1;
      ack_cyc.push_back(cyc);
    end
    if (rdata_valid) rv_total <= rv_total + 1;
    if (done) begin
      done_total <= done_total + 1;
      last_post <= gap_cnt;
    end
    if (cmd_err) err_total <= err_total + 1;
  end

  task automatic pulse_start(input logic [7:0] rw, input logic [7:0] len, input logic [15:0] addr);
    @(negedge sclk_inv);
    cmd_rw = rw;
    cmd_brstlen = len;
    cmd_addr = addr;
    start = 1'b1;
    @(negedge sclk_inv);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sclk_inv);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({ss_n, sclk, mosi, busy, done, cmd_err, rdata_valid, wdata_ack} !== 8'b1000_0000) begin
      mismatched++;
      $display("[TB] FAIL reset_pins: got %b expected 10000000", {ss_n, sclk, mosi, busy, done, cmd_err, rdata_valid, wdata_ack});
    end
    compared++;
    if (rdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata);
    end
    @(negedge sclk_inv);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk_inv);
  endtask

  task automatic test_single_write();
    int ab, mb, bb;
    bit ok;
    ab = ack_total; mb = mosi_words.size(); bb = busy_total;
    wdata = 32'hA5A5_0F0F;
    pulse_start(8'h01, 8'h00, 16'h0010);
    wait_done(ok);
    #1;
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL swr_done: got %b expected 1", ok); end
    compared++;
    if (ack_total - ab != 1) begin mismatched++; $display("[TB] FAIL swr_acks: got %0d expected 1", ack_total - ab); end
    compared++;
    if (frame_len != 64) begin mismatched++; $display("[TB] FAIL swr_frame_len: got %0d expected 64", frame_len); end
    compared++;
    if (mosi_words.size() - mb != 2) begin
      mismatched++; $display("[TB] FAIL swr_word_count: got %0d expected 2", mosi_words.size() - mb);
    end else begin
      compared++;
      if (mosi_words[mb] !== 32'h0100_0010) begin mismatched++; $display("[TB] FAIL swr_cmd_word: got %h expected 01000010", mosi_words[mb]); end
      compared++;
      if (mosi_words[mb+1] !== 32'hA5A5_0F0F) begin mismatched++; $display("[TB] FAIL swr_data_word: got %h expected a5a50f0f", mosi_words[mb+1]); end
    end
    compared++;
    if (busy_total - bb != 73) begin mismatched++; $display("[TB] FAIL swr_busy_len: got %0d expected 73", busy_total - bb); end
    compared++;
    if (last_post != SS_GAP) begin mismatched++; $display("[TB] FAIL swr_trailing_clocks: got %0d expected %0d", last_post, SS_GAP); end
  endtask

  task automatic test_single_read();
    int rb, mb;
    bit ok;
    rb = rv_total; mb = mosi_words.size();
    miso_reply = 32'hDEAD_BEEF;
    pulse_start(8'h00, 8'h00, 16'h0020);
    wait_done(ok);
    #1;
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL srd_done: got %b expected 1", ok); end
    compared++;
    if (rv_total - rb != 1) begin mismatched++; $display("[TB] FAIL srd_valid_count: got %0d expected 1", rv_total - rb); end
    compared++;
    if (rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL srd_rdata: got %h expected deadbeef", rdata); end
    compared++;
    if (mosi_words.size() - mb != 2) begin
      mismatched++; $display("[TB] FAIL srd_word_count: got %0d expected 2", mosi_words.size() - mb);
    end else begin
      compared++;
      if (mosi_words[mb] !== 32'h0000_0020) begin mismatched++; $display("[TB] FAIL srd_cmd_word: got %h expected 00000020", mosi_words[mb]); end
      compared++;
      if (mosi_words[mb+1] !== 32'h0) begin mismatched++; $display("[TB] FAIL srd_mosi_idle: got %h expected 00000000", mosi_words[mb+1]); end
    end
  endtask

  task automatic test_burst_write();
    int ab, ai, mb, bb;
    bit ok, seen;
    logic [31:0] exp_words[4];
    exp_words = '{32'h2103_0200, 32'h1, 32'h2, 32'h3};
    ab = ack_total; ai = ack_cyc.size(); mb = mosi_words.size(); bb = busy_total;
    wdata = 32'h1;
    pulse_start(8'h21, 8'd3, 16'h0200);
    for (int w = 2; w <= 3; w++) begin
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge sclk_inv);
        if (wdata_ack === 1'b1) begin seen = 1'b1; break; end
      end
      compared++;
      if (seen !== 1'b1) begin mismatched++; $display("[TB] FAIL bwr_ack_wait: got %b expected 1 (word %0d)", seen, w); end
      wdata = 32'(w);
    end
    wait_done(ok);
    #1;
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL bwr_done: got %b expected 1", ok); end
    compared++;
    if (ack_total - ab != 3) begin
      mismatched++; $display("[TB] FAIL bwr_acks: got %0d expected 3", ack_total - ab);
    end else begin
      compared++;
      if (ack_cyc[ai+1] - ack_cyc[ai] != 32) begin mismatched++; $display("[TB] FAIL bwr_ack_space1: got %0d expected 32", ack_cyc[ai+1] - ack_cyc[ai]); end
      compared++;
      if (ack_cyc[ai+2] - ack_cyc[ai+1] != 32) begin mismatched++; $display("[TB] FAIL bwr_ack_space2: got %0d expected 32", ack_cyc[ai+2] - ack_cyc[ai+1]); end
    end
    compared++;
    if (mosi_words.size() - mb != 4) begin
      mismatched++; $display("[TB] FAIL bwr_word_count: got %0d expected 4", mosi_words.size() - mb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (mosi_words[mb+i] !== exp_words[i]) begin
          mismatched++; $display("[TB] FAIL bwr_word%0d: got %h expected %h", i, mosi_words[mb+i], exp_words[i]);
        end
      end
    end
    compared++;
    if (busy_total - bb != 137) begin mismatched++; $display("[TB] FAIL bwr_busy_len: got %0d expected 137", busy_total - bb); end
  endtask

  task automatic test_errors();
    logic [7:0] rws[2];
    logic [7:0] lens[2];
    int mb;
    rws = '{8'h21, 8'h07};
    lens = '{8'h00, 8'h05};
    for (int t = 0; t < 2; t++) begin
      mb = mosi_words.size();
      pulse_start(rws[t], lens[t], 16'h0010);
      #1;
      compared++;
      if ({cmd_err, busy, ss_n, sclk} !== 4'b1010) begin
        mismatched++; $display("[TB] FAIL err_pulse_rw%h: got err/busy/ss_n/sclk=%b expected 1010", rws[t], {cmd_err, busy, ss_n, sclk});
      end
      repeat (6) @(negedge sclk_inv);
      #1;
      compared++;
      if ({cmd_err, busy, ss_n, sclk} !== 4'b0010) begin
        mismatched++; $display("[TB] FAIL err_after_rw%h: got err/busy/ss_n/sclk=%b expected 0010", rws[t], {cmd_err, busy, ss_n, sclk});
      end
      compared++;
      if (mosi_words.size() != mb) begin mismatched++; $display("[TB] FAIL err_no_frame_rw%h: got %0d words expected 0", rws[t], mosi_words.size() - mb); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int rb;
    bit ok, seen;
    miso_reply = 32'h1357_9BDF;
    pulse_start(8'h20, 8'd4, 16'h0030);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sclk_inv);
      if (rdata_valid === 1'b1) begin seen = 1'b1; break; end
    end
    compared++;
    if (seen !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_first_word_wait: got %b expected 1", seen); end
    compared++;
    if (rdata !== 32'h1357_9BDF) begin mismatched++; $display("[TB] FAIL rst_first_word: got %h expected 13579bdf", rdata); end
    repeat (10) @(negedge sclk_inv);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({ss_n, sclk, busy, mosi} !== 4'b1000) begin
      mismatched++; $display("[TB] FAIL rst_abort_pins: got ss_n/sclk/busy/mosi=%b expected 1000", {ss_n, sclk, busy, mosi});
    end
    @(negedge sclk_inv);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk_inv);
    rb = rv_total;
    miso_reply = 32'hCAFE_F00D;
    pulse_start(8'h00, 8'h00, 16'h0040);
    wait_done(ok);
    #1;
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_read_done: got %b expected 1", ok); end
    compared++;
    if (rdata !== 32'hCAFE_F00D) begin mismatched++; $display("[TB] FAIL rst_read_rdata: got %h expected cafef00d", rdata); end
    compared++;
    if (rv_total - rb != 1) begin mismatched++; $display("[TB] FAIL rst_read_valids: got %0d expected 1", rv_total - rb); end
  endtask

  task automatic test_back_to_back();
    int db, mb, eb;
    bit ok1, ok2;
    db = done_total; mb = mosi_words.size(); eb = err_total;
    wdata = 32'h1111_2222;
    @(negedge sclk_inv);
    cmd_rw = 8'h01;
    cmd_brstlen = 8'h00;
    cmd_addr = 16'h0050;
    start = 1'b1;
    wait_done(ok1);
    @(negedge sclk_inv);
    start = 1'b0;
    wait_done(ok2);
    #1;
    compared++;
    if ({ok1, ok2} !== 2'b11) begin mismatched++; $display("[TB] FAIL b2b_done: got %b expected 11", {ok1, ok2}); end
    compared++;
    if (done_total - db != 2) begin mismatched++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_total - db); end
    compared++;
    if (mosi_words.size() - mb != 4) begin mismatched++; $display("[TB] FAIL b2b_word_count: got %0d expected 4", mosi_words.size() - mb); end
    compared++;
    if (last_gap < 2 * SS_GAP) begin mismatched++; $display("[TB] FAIL b2b_gap: got %0d expected >= %0d", last_gap, 2 * SS_GAP); end
    compared++;
    if (err_total != eb) begin mismatched++; $display("[TB] FAIL b2b_no_err: got %0d expected 0", err_total - eb); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write();
    test_errors();
    test_reset_mid_burst();
    test_back_to_back();
    repeat (4) @(negedge sclk_inv);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule

// File: doc/spim_intf.md
Name: spim_intf

Overview:
- SPI master engine for the SPI slave interface (spis side): generates sclk, ss_n and mosi, and samples miso.
- Mode is CPOL=0 / CPHA=0.
- Frames one host request as a 32-bit command word {rw[7:0], brstlen[7:0], addr[15:0]} followed by N 32-bit data words, MSB first.
- Sits between a host/test controller and the SPI pins; all logic is clocked by the free-running sclk_inv.

Parameters:
- SS_GAP, 4: sclk cycles with ss_n high and sclk toggling, both before the command and after the last data word. Minimum 2, so the slave's ss_n edge detectors see both edges.
- CW, 5: bit-counter width (32-bit words); fixed, not for override.

Ports:
- sclk_inv  in  1  free-running clock; pin sclk is its gated inverse
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy
- cmd_rw  in  8  0x00 single read, 0x01 single write, 0x20 burst read, 0x21 burst write
- cmd_brstlen  in  8  burst word count (burst commands only)
- cmd_addr  in  16  register address
- wdata  in  32  write data word; sampled when wdata_ack is high
- wdata_ack  out  1  pulse: wdata taken into the shift register; host presents the next word by the following cycle
- rdata  out  32  read word
- rdata_valid  out  1  one-cycle pulse per read word
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of transaction
- cmd_err  out  1  one-cycle pulse: start rejected
- sclk  out  1  SPI clock
- ss_n  out  1  SPI select, active low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in

Behaviour:
- Clocking and reset:
  - All flops are posedge sclk_inv (i.e. sclk falling), except the miso capture flop, which is negedge sclk_inv (sclk rising).
  - Reset is asynchronous and active-low on rst_n.
  - Reset values: ss_n=1, sclk=0 (gate off), mosi=0, busy=0, done=0, cmd_err=0, rdata=0, rdata_valid=0, wdata_ack=0, FSM=IDLE.
  - Reset mid-transaction: abort immediately; the pins return to the reset values.
- Word count N (latched at start):
  - rw 0x00 or 0x01: N=1.
  - rw 0x20 or 0x21: N=brstlen.
  - Reject condition: brstlen=0 on a burst command, or any other rw value.
  - On reject: cmd_err pulses the cycle after start, busy stays 0, and no pin activity occurs.
- FSM states: IDLE -> PRE -> CMD -> DATA -> POST -> DONE -> IDLE.
  - IDLE: on start & valid command: latch rw, N, addr; set busy; sclk_en=1; ss_n stays 1 → PRE.
  - PRE: SS_GAP cycles with ss_n=1; at the last cycle, drive ss_n=0, load the command word into the tx shift register, mosi=bit31 → CMD.
  - CMD: 32 cycles shifting mosi MSB first, one bit per posedge sclk_inv. At bit count 31 (the last cycle):
    - write command: load wdata, pulse wdata_ack.
    - read command: load zero.
    - Then → DATA.
  - DATA: N words of 32 cycles each, with a word counter decrementing at each word end.
    - Write: at each word end with words remaining, load wdata and pulse wdata_ack (N pulses total, the first at CMD end).
    - Read: mosi=0. miso is captured into rx shift on negedge; at each word end, rdata is updated and rdata_valid pulses on the next posedge.
    - Last word end → POST: ss_n=1.
  - POST: SS_GAP cycles, sclk still toggling; then sclk_en=0 → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- busy stays high through DONE's cycle and drops together with the done pulse.
- sclk gating: sclk = ~sclk_inv & sclk_en. sclk_en changes only on posedge sclk_inv, when ~sclk_inv is low, so the gate is glitch-free.
- Counters:
  - Bit counter: 5-bit, wraps 31→0.
  - Word counter: 8-bit; N=255 is legal.
- start is ignored while busy (no cmd_err).
- A start in the DONE cycle is ignored.

Decomposition:
- Shared package spi_pkg:
  - command opcodes CMD_SRD=8'h00, CMD_SWR=8'h01, CMD_BRD=8'h20, CMD_BWR=8'h21;
  - FSM state enum;
  - word width 32.
- Sub-module spim_clk_gate (AND-gate sclk generation with the registered enable) isolates the clock-gating cell for later technology swap.

Test Plan:
- Single write: rw=0x01, addr=0x0010, wdata=0xA5A5_0F0F.
  - mosi stream = 0x01000010 then 0xA5A5_0F0F.
  - Exactly 1 wdata_ack; ss_n low for exactly 64 sclk; done after SS_GAP trailing clocks.
- Single read: rw=0x00, addr=0x0020; miso model returns 0xDEAD_BEEF in slot 2.
  - rdata=0xDEADBEEF with one rdata_valid pulse; mosi=0 during the data slot.
- Burst write: rw=0x21, brstlen=3, wdata sequence 1,2,3.
  - 3 wdata_ack pulses spaced 32 cycles apart; mosi words 0x21030200, 1, 2, 3; busy for 4*32+2*SS_GAP+PRE/DONE cycles.
- Errors: rw=0x21 with brstlen=0 → cmd_err pulse, busy=0, ss_n=1, sclk=0. Same result for rw=0x07.
- Reset mid-burst-read (brstlen=4, during word 2) → ss_n=1, sclk=0, busy=0 immediately.
  - A subsequent single read completes correctly.
- Back-to-back: start held high through done → second transaction begins only after IDLE; ss_n high ≥ 2*SS_GAP sclk between the two frames.
- End-to-end: connect to spis_intf and its register model; write 0x1234_5678 to 0x0010, then read it back → rdata matches.
